wb_crc_stream_feeder: RTL and testbench

//  Upstream feeder for the wb_crc32 peripheral. Accepts a valid/ready stream of 32-bit words with an
//  end-of-frame marker and buffers it in a small FIFO. Acts as Wishbone B3 classic master: seeds the CRC,

---
 rtl/wb_crc_stream_feeder_pkg.sv | 32 +++
 rtl/wb_crc_stream_feeder_if.sv | 40 ++++
 rtl/wb_crc_stream_feeder_fifo.sv | 62 ++++++
 rtl/wb_crc_stream_feeder.sv | 187 ++++++++++++++++++
 tb/tb_wb_crc_stream_feeder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_crc_stream_feeder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : crc_feeder_pkg                                                |
// | Purpose  : Shared types and constants for the wb_crc32 stream feeder:    |
// |            FSM state encoding, FIFO entry layout, default register map.  |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package crc_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } fifo_entry_t;

   localparam logic [31:0] DEF_DATA_ADR   = 32'h0000_0000;
   localparam logic [31:0] DEF_INIT_ADR   = 32'h0008_0000;
   localparam logic [31:0] DEF_RESULT_ADR = 32'h0008_0004;
   localparam logic [31:0] DEF_INIT_VAL   = 32'hFFFF_FFFF;
   localparam logic [2:0]  CTI_CLASSIC    = 3'b000;
   localparam logic [3:0]  SEL_ALL        = 4'hF;

endpackage
`default_nettype wire

// File: rtl/wb_crc_stream_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : crc_stream_if / crc_wb_if                                     |
// | Purpose  : Bundles for the inbound word stream and the Wishbone B3       |
// |            classic bus towards the CRC slave.                            |
// | Ports    : crc_stream_if  s_data_i, s_valid_i, s_last_i, s_ready_o       |
// |            crc_wb_if      wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,         |
// |                           wb_cti_o, wb_cyc_o, wb_stb_o, wb_dat_i,        |
// |                           wb_ack_i                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface crc_stream_if;
   logic [31:0] s_data_i;
   logic        s_valid_i;
   logic        s_last_i;
   logic        s_ready_o;

   modport master (output s_data_i, s_valid_i, s_last_i, input s_ready_o);
   modport slave  (input s_data_i, s_valid_i, s_last_i, output s_ready_o);
endinterface

interface crc_wb_if;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic [2:0]  wb_cti_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   modport master (output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o,
                          wb_cyc_o, wb_stb_o,
                   input  wb_dat_i, wb_ack_i);
   modport slave  (input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cti_o,
                          wb_cyc_o, wb_stb_o,
                   output wb_dat_i, wb_ack_i);
endinterface
`default_nettype wire

// File: rtl/wb_crc_stream_feeder_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : crc_feeder_fifo                                               |
// | Purpose  : Synchronous FIFO holding {last,data} stream entries.          |
// | Ports    : clk, rst_n (sync, active-low), i_push/i_data, i_pop,          |
// |            o_data (head), o_full (registered), o_count                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module crc_feeder_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 33
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       i_push,
   input  wire logic [WIDTH-1:0]           i_data,
   input  wire logic                       i_pop,
   output logic      [WIDTH-1:0]           o_data,
   output logic                            o_full,
   output logic      [$clog2(DEPTH):0]     o_count
);
   localparam int             AW         = $clog2(DEPTH);
   localparam logic [AW:0]    C_FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_full;
   logic             w_push;
   logic             w_pop;
   logic [AW:0]      w_count_nxt;

   // A push is refused whenever full, even if a pop frees a slot this cycle.
   assign w_push      = i_push && !r_full;
   assign w_pop       = i_pop && (r_count != '0);
   assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == C_FULL_CNT);
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/wb_crc_stream_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_crc_stream_feeder                                          |
// | Purpose  : Buffers a framed 32-bit word stream and feeds it to the       |
// |            wb_crc32 slave as a Wishbone classic master: seed, data       |
// |            writes, result read; reports the CRC as a one-cycle pulse.    |
// | Ports    : wb_clk_i, wb_rst_i (sync, active-low)                         |
// |            s  : stream sink (crc_stream_if.slave)                        |
// |            wb : Wishbone master (crc_wb_if.master)                       |
// |            crc_o, crc_valid_o, crc_err_o, busy_o                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module wb_crc_stream_feeder
   import crc_feeder_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] DATA_ADR   = DEF_DATA_ADR,
   parameter logic [31:0] INIT_ADR   = DEF_INIT_ADR,
   parameter logic [31:0] RESULT_ADR = DEF_RESULT_ADR,
   parameter logic [31:0] INIT_VAL   = DEF_INIT_VAL,
   parameter int          TIMEOUT    = 16
) (
   input  wire logic        wb_clk_i,
   input  wire logic        wb_rst_i,
   crc_stream_if.slave      s,
   crc_wb_if.master         wb,
   output logic [31:0]      crc_o,
   output logic             crc_valid_o,
   output logic             crc_err_o,
   output logic             busy_o
);
   localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
   localparam int            TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

   state_t        r_state;
   logic          r_frame_start;
   logic          r_stb;
   logic [31:0]   r_adr;
   logic [31:0]   r_dat;
   logic          r_we;
   logic [TW-1:0] r_tmo;
   logic [31:0]   r_crc;
   logic          r_crc_valid;
   logic          r_crc_err;

   fifo_entry_t   w_head;
   logic          w_full;
   logic [CW-1:0] w_count;
   logic          w_empty;
   logic          w_ack;
   logic          w_tmo_hit;
   logic          w_pop;

   crc_feeder_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_i),
      .i_push  (s.s_valid_i),
      .i_data  ({s.s_last_i, s.s_data_i}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_count (w_count)
   );

   assign w_empty   = (w_count == '0);
   assign w_ack     = r_stb && wb.wb_ack_i;
   // Fires on the last of TIMEOUT consecutive unacknowledged strobe cycles,
   // so the strobe is high for exactly TIMEOUT cycles before the abort.
   assign w_tmo_hit = r_stb && !wb.wb_ack_i && (r_tmo == C_TMO_LAST);
   assign w_pop     = ((r_state == ST_WRITE) && w_ack) ||
                      ((r_state == ST_DRAIN) && !w_empty);

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         r_state       <= ST_IDLE;
         r_frame_start <= 1'b1;
         r_stb         <= 1'b0;
         r_adr         <= '0;
         r_dat         <= '0;
         r_we          <= 1'b0;
         r_tmo         <= '0;
         r_crc         <= '0;
         r_crc_valid   <= 1'b0;
         r_crc_err     <= 1'b0;
      end else begin
         r_crc_valid <= 1'b0;
         r_crc_err   <= 1'b0;

         // Every state change drops the strobe, so this also clears on exit.
         if (r_stb && !wb.wb_ack_i && !w_tmo_hit) r_tmo <= r_tmo + TW'(1);
         else                                     r_tmo <= '0;

         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_stb <= 1'b1;
                  r_we  <= 1'b1;
                  if (r_frame_start) begin
                     r_state <= ST_INIT;
                     r_adr   <= INIT_ADR;
                     r_dat   <= INIT_VAL;
                  end else begin
                     r_state <= ST_WRITE;
                     r_adr   <= DATA_ADR;
                     r_dat   <= w_head.data;
                  end
               end
            end
            ST_INIT: begin
               if (w_ack) begin
                  r_stb         <= 1'b0;
                  r_frame_start <= 1'b0;
                  r_state       <= ST_IDLE;
               end else if (w_tmo_hit) begin
                  r_stb   <= 1'b0;
                  r_state <= ST_DRAIN;
               end
            end
            ST_WRITE: begin
               if (w_ack) begin
                  r_stb <= 1'b0;
                  if (w_head.last) begin
                     // Load the read address now; strobe rises after one idle cycle.
                     r_state <= ST_READ;
                     r_adr   <= RESULT_ADR;
                     r_dat   <= '0;
                     r_we    <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else if (w_tmo_hit) begin
                  r_stb   <= 1'b0;
                  r_state <= ST_DRAIN;
               end
            end
            ST_READ: begin
               if (!r_stb) begin
                  r_stb <= 1'b1;
               end else if (w_ack) begin
                  r_stb         <= 1'b0;
                  r_crc         <= wb.wb_dat_i;
                  r_crc_valid   <= 1'b1;
                  r_frame_start <= 1'b1;
                  r_state       <= ST_IDLE;
               end else if (w_tmo_hit) begin
                  // Last word was already consumed; nothing left to drain.
                  r_stb         <= 1'b0;
                  r_crc_err     <= 1'b1;
                  r_frame_start <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!w_empty && w_head.last) begin
                  r_crc_err     <= 1'b1;
                  r_frame_start <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            default: begin
               r_stb   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign s.s_ready_o = !w_full;

   assign wb.wb_adr_o = r_adr;
   assign wb.wb_dat_o = r_dat;
   assign wb.wb_we_o  = r_we;
   assign wb.wb_sel_o = SEL_ALL;
   assign wb.wb_cti_o = CTI_CLASSIC;
   assign wb.wb_cyc_o = r_stb;
   assign wb.wb_stb_o = r_stb;

   assign crc_o       = r_crc;
   assign crc_valid_o = r_crc_valid;
   assign crc_err_o   = r_crc_err;
   assign busy_o      = (r_state != ST_IDLE) || !w_empty;
endmodule
`default_nettype wire

// File: tb/tb_wb_crc_stream_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wb_crc_stream_feeder                                       |
// | Purpose  : Self-checking bench for wb_crc_stream_feeder with a Wishbone  |
// |            slave model (0-3 wait states, write log, fixed read data).    |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_wb_crc_stream_feeder;
   localparam logic [31:0] T_DATA_ADR   = 32'h0000_0000;
   localparam logic [31:0] T_INIT_ADR   = 32'h0008_0000;
   localparam logic [31:0] T_RESULT_ADR = 32'h0008_0004;
   localparam logic [31:0] T_INIT_VAL   = 32'hFFFF_FFFF;

   typedef struct {
      int              n;
      logic [3:0][31:0] w;
      logic [31:0]     rd;
      logic [31:0]     exp_crc;
      int              exp_txn;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] crc;
   logic        crc_valid;
   logic        crc_err;
   logic        busy;

   crc_stream_if st ();
   crc_wb_if     wbi ();

   wb_crc_stream_feeder dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .s           (st),
      .wb          (wbi),
      .crc_o       (crc),
      .crc_valid_o (crc_valid),
      .crc_err_o   (crc_err),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   int          errors    = 0;
   int          checks    = 0;
   int          valid_cnt = 0;
   int          err_cnt   = 0;
   int          run       = 0;
   int          max_run   = 0;
   int          wait_cnt  = 0;
   logic        stall_all = 1'b0;
   logic        stall_en  = 1'b0;
   logic [31:0] stall_dat = '0;
   logic [31:0] result_val = 32'hCAFE_F00D;
   logic        hold_pend = 1'b0;
   logic [64:0] hold_val  = '0;
   logic [64:0] wlog [$];

   // Monitor (pulses, protocol) followed by the slave model; one process so
   // the monitor sees the ack the DUT sampled at the preceding rising edge.
   always @(negedge clk) begin : mon_slave
      logic bad;
      logic stall;
      if (crc_valid) valid_cnt++;
      if (crc_err)   err_cnt++;
      if (rst_n) begin
         bad = (wbi.wb_cyc_o !== wbi.wb_stb_o) || (wbi.wb_cti_o !== 3'b000) ||
               (wbi.wb_sel_o !== 4'hF) || (crc_valid && crc_err) ||
               (wbi.wb_ack_i && wbi.wb_stb_o) ||
               (hold_pend && wbi.wb_stb_o &&
                ({wbi.wb_adr_o, wbi.wb_dat_o, wbi.wb_we_o} !== hold_val));
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL protocol @%0t: cyc=%b stb=%b cti=%h sel=%h ack=%b v=%b e=%b got adr/dat/we=%h held=%h",
                     $time, wbi.wb_cyc_o, wbi.wb_stb_o, wbi.wb_cti_o, wbi.wb_sel_o, wbi.wb_ack_i,
                     crc_valid, crc_err, {wbi.wb_adr_o, wbi.wb_dat_o, wbi.wb_we_o}, hold_val);
         end
      end
      if (wbi.wb_stb_o) run++;
      else begin
         if (run > max_run) max_run = run;
         run = 0;
      end
      stall = stall_all || (stall_en && wbi.wb_we_o && (wbi.wb_dat_o == stall_dat));
      if (!rst_n || !wbi.wb_stb_o || wbi.wb_ack_i) begin
         wbi.wb_ack_i = 1'b0;
         wait_cnt     = $urandom_range(0, 3);
      end else if (!stall) begin
         if (wait_cnt == 0) begin
            wbi.wb_ack_i = 1'b1;
            wlog.push_back({wbi.wb_adr_o, wbi.wb_dat_o, wbi.wb_we_o});
            if (!wbi.wb_we_o) wbi.wb_dat_i = result_val;
         end else begin
            wait_cnt--;
         end
      end
      hold_pend = rst_n && wbi.wb_stb_o && !wbi.wb_ack_i;
      hold_val  = {wbi.wb_adr_o, wbi.wb_dat_o, wbi.wb_we_o};
   end

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [64:0] lget(input int i);
      return (i < wlog.size()) ? wlog[i] : 65'h0;
   endfunction

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic push(input logic [31:0] d, input logic l);
      logic rdy;
      bit   ok = 0;
      st.s_data_i  = d;
      st.s_last_i  = l;
      st.s_valid_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         rdy = st.s_ready_o;
         @(negedge clk);
         if (rdy) begin ok = 1; break; end
      end
      st.s_valid_i = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL push_timeout: word %h not accepted, required acceptance", d);
      end
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy && !wbi.wb_cyc_o) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s_idle_timeout: busy=%b, required 0", nm, busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_stats();
      wlog.delete();
      valid_cnt = 0;
      err_cnt   = 0;
      max_run   = 0;
   endtask

   initial begin : main
      vec_t vecs [3];
      vec_t v;
      vecs[0] = '{3, {32'h0, 32'h0404_0404, 32'h0202_0202, 32'h0101_0101},
                  32'hCAFE_F00D, 32'hCAFE_F00D, 5};
      vecs[1] = '{1, {32'h0, 32'h0, 32'h0, 32'h0000_0011},
                  32'h1234_5678, 32'h1234_5678, 3};
      vecs[2] = '{4, {32'h1111_0004, 32'h1111_0003, 32'h1111_0002, 32'h1111_0001},
                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 6};

      st.s_data_i  = '0;
      st.s_valid_i = 1'b0;
      st.s_last_i  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state, sampled while reset is still applied.
      chk("rst_ready", 96'(st.s_ready_o), 96'd1);
      chk("rst_cyc_stb", 96'({wbi.wb_cyc_o, wbi.wb_stb_o}), 96'd0);
      chk("rst_crc", 96'(crc), 96'd0);
      chk("rst_pulses_busy", 96'({crc_valid, crc_err, busy}), 96'd0);
      chk("rst_adr_dat_we", 96'({wbi.wb_adr_o, wbi.wb_dat_o, wbi.wb_we_o}), 96'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven single frames.
      for (int k = 0; k < 3; k++) begin
         v = vecs[k];
         clear_stats();
         result_val = v.rd;
         for (int i = 0; i < v.n; i++) push(v.w[i], i == v.n - 1);
         wait_idle($sformatf("vec%0d", k));
         chk($sformatf("vec%0d_txn_count", k), 96'(wlog.size()), 96'(v.exp_txn));
         chk($sformatf("vec%0d_init", k), 96'(lget(0)), 96'({T_INIT_ADR, T_INIT_VAL, 1'b1}));
         for (int i = 0; i < v.n; i++)
            chk($sformatf("vec%0d_write%0d", k, i), 96'(lget(i + 1)),
                96'({T_DATA_ADR, v.w[i], 1'b1}));
         chk($sformatf("vec%0d_read", k), 96'({lget(v.n + 1)[64:33], lget(v.n + 1)[0]}),
             96'({T_RESULT_ADR, 1'b0}));
         chk($sformatf("vec%0d_crc", k), 96'(crc), 96'(v.exp_crc));
         chk($sformatf("vec%0d_pulses", k), 96'({valid_cnt[7:0], err_cnt[7:0]}), 96'h0100);
      end

      // Two back-to-back one-word frames.
      clear_stats();
      result_val = 32'hCAFE_F00D;
      push(32'h0000_0055, 1'b1);
      push(32'h0000_0066, 1'b1);
      wait_idle("b2b");
      chk("b2b_txn_count", 96'(wlog.size()), 96'd6);
      chk("b2b_init0", 96'(lget(0)), 96'({T_INIT_ADR, T_INIT_VAL, 1'b1}));
      chk("b2b_write0", 96'(lget(1)), 96'({T_DATA_ADR, 32'h0000_0055, 1'b1}));
      chk("b2b_read0", 96'({lget(2)[64:33], lget(2)[0]}), 96'({T_RESULT_ADR, 1'b0}));
      chk("b2b_init1", 96'(lget(3)), 96'({T_INIT_ADR, T_INIT_VAL, 1'b1}));
      chk("b2b_write1", 96'(lget(4)), 96'({T_DATA_ADR, 32'h0000_0066, 1'b1}));
      chk("b2b_read1", 96'({lget(5)[64:33], lget(5)[0]}), 96'({T_RESULT_ADR, 1'b0}));
      chk("b2b_pulses", 96'({valid_cnt[7:0], err_cnt[7:0]}), 96'h0200);

      // Stalled slave while the FIFO fills.
      clear_stats();
      stall_all = 1'b1;
      for (int i = 0; i < 8; i++) push(32'hF000_0000 + 32'(i), i == 7);
      chk("fill_ready_full", 96'(st.s_ready_o), 96'd0);
      st.s_data_i  = 32'hF000_0008;
      st.s_last_i  = 1'b1;
      st.s_valid_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("fill_ready_still_full", 96'(st.s_ready_o), 96'd0);
      st.s_valid_i = 1'b0;
      stall_all    = 1'b0;
      wait_idle("fill");
      chk("fill_txn_count", 96'(wlog.size()), 96'd10);
      chk("fill_init", 96'(lget(0)), 96'({T_INIT_ADR, T_INIT_VAL, 1'b1}));
      for (int i = 0; i < 8; i++)
         chk($sformatf("fill_write%0d", i), 96'(lget(i + 1)),
             96'({T_DATA_ADR, 32'hF000_0000 + 32'(i), 1'b1}));
      chk("fill_pulses", 96'({valid_cnt[7:0], err_cnt[7:0]}), 96'h0100);

      // Bus timeout on the second word of a four-word frame.
      clear_stats();
      stall_en  = 1'b1;
      stall_dat = 32'hA000_0002;
      for (int i = 1; i <= 4; i++) push(32'hA000_0000 + 32'(i), i == 4);
      wait_idle("tmo");
      stall_en = 1'b0;
      chk("tmo_stb_cycles", 96'(max_run), 96'd16);
      chk("tmo_pulses", 96'({valid_cnt[7:0], err_cnt[7:0]}), 96'h0001);
      chk("tmo_txn_count", 96'(wlog.size()), 96'd2);
      chk("tmo_write0", 96'(lget(1)), 96'({T_DATA_ADR, 32'hA000_0001, 1'b1}));
      clear_stats();
      push(32'hB000_0001, 1'b1);
      wait_idle("tmo_next");
      chk("tmo_next_txn_count", 96'(wlog.size()), 96'd3);
      chk("tmo_next_init", 96'(lget(0)), 96'({T_INIT_ADR, T_INIT_VAL, 1'b1}));
      chk("tmo_next_write", 96'(lget(1)), 96'({T_DATA_ADR, 32'hB000_0001, 1'b1}));
      chk("tmo_next_pulses", 96'({valid_cnt[7:0], err_cnt[7:0]}), 96'h0100);

      // Reset asserted while a data write is strobing.
      stall_en  = 1'b1;
      stall_dat = 32'hC000_0001;
      push(32'hC000_0001, 1'b0);
      push(32'hC000_0002, 1'b1);
      begin : wait_write
         bit seen = 0;
         for (int i = 0; i < 50; i++) begin
            if (wbi.wb_stb_o && wbi.wb_we_o && wbi.wb_dat_o == 32'hC000_0001) begin
               seen = 1; break;
            end
            @(negedge clk);
         end
         chk("mid_rst_write_seen", 96'(seen), 96'd1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_cyc_stb", 96'({wbi.wb_cyc_o, wbi.wb_stb_o}), 96'd0);
      chk("mid_rst_ready_busy", 96'({st.s_ready_o, busy}), 96'b10);
      chk("mid_rst_crc", 96'(crc), 96'd0);
      rst_n    = 1'b1;
      stall_en = 1'b0;
      @(negedge clk);
      clear_stats();
      push(32'hD000_0001, 1'b1);
      wait_idle("post_rst");
      chk("post_rst_txn_count", 96'(wlog.size()), 96'd3);
      chk("post_rst_init", 96'(lget(0)), 96'({T_INIT_ADR, T_INIT_VAL, 1'b1}));
      chk("post_rst_write", 96'(lget(1)), 96'({T_DATA_ADR, 32'hD000_0001, 1'b1}));
      chk("post_rst_pulses", 96'({valid_cnt[7:0], err_cnt[7:0]}), 96'h0100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
